// File: rtl/cv32e41p_hwloop_controller.sv
// Hardware-loop controller: detects loop-end instructions leaving ID, strobes the
// per-loop counter decrement and holds a jump request to fetch until it is accepted.
module cv32e41p_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc_id_i,
    input  logic                  instr_valid_id_i,
    input  logic                  id_ready_i,
    input  logic                  flush_i,
    input  logic [31:0]           hwlp_start_addr_i [N_REGS],
    input  logic [31:0]           hwlp_end_addr_i   [N_REGS],
    input  logic [31:0]           hwlp_counter_i    [N_REGS],
    input  logic                  if_ready_i,
    output logic [N_REGS-1:0]     hwlp_dec_cnt_o,
    output logic                  hwlp_jump_o,
    output logic [31:0]           hwlp_target_o,
    output logic [N_REGS-1:0]     hwlp_active_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                state_r;
    logic [31:0]           target_r;

    logic                  advance_s;
    logic [N_REGS-1:0]     match_s;
    logic [N_REGS-1:0]     active_s;
    logic                  any_match_s;
    logic [N_REG_BITS-1:0] sel_s;
    logic [31:0]           sel_count_s;
    logic [31:0]           sel_start_s;
    logic                  iterate_s;
    logic [N_REGS-1:0]     dec_s;

    assign advance_s = instr_valid_id_i & id_ready_i & ~flush_i;

    // Per-loop end-address compare; the last body instruction sits one word before end.
    always_comb begin
        match_s  = '0;
        active_s = '0;
        for (int k = 0; k < N_REGS; k++) begin
            active_s[k] = (hwlp_counter_i[k] != 32'd0);
            match_s[k]  = (pc_id_i == (hwlp_end_addr_i[k] - 32'd4)) && active_s[k];
        end
    end

    // Priority select: scanning downwards leaves the lowest (innermost) match in sel_s.
    always_comb begin
        any_match_s = 1'b0;
        sel_s       = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match_s[k]) begin
                any_match_s = 1'b1;
                sel_s       = N_REG_BITS'(k);
            end else begin
                any_match_s = any_match_s;
                sel_s       = sel_s;
            end
        end
    end

    assign sel_count_s = hwlp_counter_i[sel_s];
    assign sel_start_s = hwlp_start_addr_i[sel_s];
    // A count of 1 is the final pass: decrement only, fall through to the exit.
    assign iterate_s   = advance_s & any_match_s & (sel_count_s > 32'd1);

    // One-hot decrement strobe; flush and stalls suppress it through advance_s.
    always_comb begin
        dec_s = '0;
        if (advance_s && any_match_s) begin
            dec_s[sel_s] = 1'b1;
        end else begin
            dec_s = '0;
        end
    end

    // Jump-request FSM; the target is captured at issue so later register writes cannot move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            target_r <= 32'h0000_0000;
        end else if (flush_i) begin
            state_r  <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iterate_s) begin
                        state_r  <= PEND;
                        target_r <= sel_start_s;
                    end
                end
                PEND: begin
                    if (iterate_s) begin
                        state_r  <= PEND;
                        target_r <= sel_start_s;
                    end else if (if_ready_i) begin
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hwlp_dec_cnt_o = dec_s;
    assign hwlp_active_o  = active_s;
    assign hwlp_jump_o    = (state_r == PEND);
    assign hwlp_target_o  = target_r;

endmodule
